// File: rtl/histogram_pkg.sv
// Shared types and defaults for the histogram dataflow control slice.
package histogram_pkg;

   localparam int unsigned ITER_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } ctrl_state_e;

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Full/empty bookkeeping for the two ping-pong histogram banks plus the
// producer (write) and consumer (read) bank pointers.
module pingpong_bank_tracker (
   input  logic       ap_clk,
   input  logic       ap_rst_n,
   input  logic       clear,
   input  logic       set_fire,
   input  logic       clr_fire,
   output logic       prod_bank,
   output logic       cons_bank,
   output logic       prod_ok,
   output logic       cons_ok,
   output logic [1:0] bank_full
);

   logic [1:0] full_q, full_d;
   logic       prod_bank_q, prod_bank_d;
   logic       cons_bank_q, cons_bank_d;

   // Next-state: producer completion fills its bank, consumer completion drains its bank.
   // Both may fire in one cycle; they always address different banks.
   always_comb begin
      full_d      = full_q;
      prod_bank_d = prod_bank_q;
      cons_bank_d = cons_bank_q;
      if (clear) begin
         full_d      = 2'b00;
         prod_bank_d = 1'b0;
         cons_bank_d = 1'b0;
      end else begin
         if (set_fire) begin
            full_d[prod_bank_q] = 1'b1;
            prod_bank_d         = ~prod_bank_q;
         end
         if (clr_fire) begin
            full_d[cons_bank_q] = 1'b0;
            cons_bank_d         = ~cons_bank_q;
         end
      end
   end

   // Flag and pointer registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         full_q      <= 2'b00;
         prod_bank_q <= 1'b0;
         cons_bank_q <= 1'b0;
      end else begin
         full_q      <= full_d;
         prod_bank_q <= prod_bank_d;
         cons_bank_q <= cons_bank_d;
      end
   end

   assign prod_bank = prod_bank_q;
   assign cons_bank = cons_bank_q;
   assign prod_ok   = ~full_q[prod_bank_q];
   assign cons_ok   = full_q[cons_bank_q];
   assign bank_full = full_q;

endmodule

// File: rtl/histogram_pingpong_ctrl.sv
// Sequences the map (producer) and reduce (consumer) stages over two
// ping-pong histogram banks behind an ap_ctrl_hs top-level handshake.
module histogram_pingpong_ctrl
   import histogram_pkg::*;
#(
   parameter int unsigned ITER_W = ITER_W_DEFAULT
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   input  logic [ITER_W-1:0] num_frames,
   output logic              ap_done,
   output logic              ap_ready,
   output logic              ap_idle,
   output logic              prod_start,
   input  logic              prod_done,
   output logic              prod_continue,
   output logic              prod_bank,
   output logic              cons_start,
   input  logic              cons_done,
   output logic              cons_continue,
   output logic              cons_bank,
   output logic [1:0]        bank_full
);

   ctrl_state_e       state_q, state_d;
   logic [ITER_W-1:0] frames_q, prod_cnt_q, cons_cnt_q;
   logic              prod_start_q, cons_start_q;
   logic              start_acc, prod_fire, cons_fire;
   logic              prod_ok, cons_ok, prod_launch, cons_launch;

   assign start_acc   = (state_q == StIdle) & ap_start;
   // A done only counts while its start is held; stray dones are just echoed.
   assign prod_fire   = prod_start_q & prod_done;
   assign cons_fire   = cons_start_q & cons_done;
   assign prod_launch = (state_q == StRun) & ~prod_start_q & prod_ok & (prod_cnt_q < frames_q);
   assign cons_launch = (state_q == StRun) & ~cons_start_q & cons_ok;

   pingpong_bank_tracker u_tracker (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .clear     (start_acc),
      .set_fire  (prod_fire),
      .clr_fire  (cons_fire),
      .prod_bank (prod_bank),
      .cons_bank (cons_bank),
      .prod_ok   (prod_ok),
      .cons_ok   (cons_ok),
      .bank_full (bank_full)
   );

   // FSM state register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_q <= StIdle;
      else           state_q <= state_d;
   end

   // FSM next state: run ends once every frame has been consumed.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (ap_start) state_d = StRun;
         StRun:   if (cons_cnt_q == frames_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs for the top-level handshake.
   always_comb begin
      ap_done  = (state_q == StDone);
      ap_ready = (state_q == StDone);
      ap_idle  = (state_q == StIdle) & ~ap_start;
   end

   // Frame budget and per-stage completion counters.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         frames_q   <= '0;
         prod_cnt_q <= '0;
         cons_cnt_q <= '0;
      end else if (start_acc) begin
         frames_q   <= num_frames;
         prod_cnt_q <= '0;
         cons_cnt_q <= '0;
      end else begin
         if (prod_fire) prod_cnt_q <= prod_cnt_q + ITER_W'(1);
         if (cons_fire) cons_cnt_q <= cons_cnt_q + ITER_W'(1);
      end
   end

   // Stage start registers: held from launch until the stage reports done.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         prod_start_q <= 1'b0;
         cons_start_q <= 1'b0;
      end else if (start_acc) begin
         prod_start_q <= 1'b0;
         cons_start_q <= 1'b0;
      end else begin
         if (prod_fire)        prod_start_q <= 1'b0;
         else if (prod_launch) prod_start_q <= 1'b1;
         if (cons_fire)        cons_start_q <= 1'b0;
         else if (cons_launch) cons_start_q <= 1'b1;
      end
   end

   assign prod_start    = prod_start_q;
   assign cons_start    = cons_start_q;
   // Continue mirrors done so the stages never latch a done.
   assign prod_continue = prod_done;
   assign cons_continue = cons_done;

endmodule

// File: tb/tb_histogram_pingpong_ctrl.sv
// Bench for histogram_pingpong_ctrl: table of whole-run vectors driven through
// auto-responding stage models, plus hand sequences for corner cases.
module tb_histogram_pingpong_ctrl;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b1;
   logic        ap_start = 1'b0;
   logic [15:0] num_frames = '0;
   logic        ap_done, ap_ready, ap_idle;
   logic        prod_start, prod_continue, prod_bank;
   logic        cons_start, cons_continue, cons_bank;
   logic [1:0]  bank_full;
   logic        prod_done, cons_done;
   logic        man_prod_done = 1'b0, man_cons_done = 1'b0;
   logic        auto_prod_done = 1'b0, auto_cons_done = 1'b0;
   logic        manual = 1'b1;

   assign prod_done = manual ? man_prod_done : auto_prod_done;
   assign cons_done = manual ? man_cons_done : auto_cons_done;

   histogram_pingpong_ctrl #(.ITER_W(16)) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .ap_start      (ap_start),
      .num_frames    (num_frames),
      .ap_done       (ap_done),
      .ap_ready      (ap_ready),
      .ap_idle       (ap_idle),
      .prod_start    (prod_start),
      .prod_done     (prod_done),
      .prod_continue (prod_continue),
      .prod_bank     (prod_bank),
      .cons_start    (cons_start),
      .cons_done     (cons_done),
      .cons_continue (cons_continue),
      .cons_bank     (cons_bank),
      .bank_full     (bank_full)
   );

   always #5 ap_clk = ~ap_clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Stage models: pulse done for one cycle after a programmable latency.
   int plat = 2, clat = 2, pcnt = 0, ccnt = 0;
   initial forever begin
      @(posedge ap_clk);
      #1;
      if (!manual && prod_start && !auto_prod_done) begin
         pcnt++;
         if (pcnt >= plat) begin auto_prod_done = 1'b1; pcnt = 0; end
      end else auto_prod_done = 1'b0;
      if (!manual && cons_start && !auto_cons_done) begin
         ccnt++;
         if (ccnt >= clat) begin auto_cons_done = 1'b1; ccnt = 0; end
      end else auto_cons_done = 1'b0;
   end

   // Scoreboard / monitor state.
   bit   mon_en = 1'b0;
   int   mtick = 0;
   logic exp_prod_q[$];
   logic exp_cons_q[$];
   logic pp = 1'b0, cp = 1'b0;
   int   prod_seen, cons_seen, cons_fires, done_pulses, cur_nf;
   bit   saw_full11;
   int   stall_dl = -1, cons_dl = -1, done_dl = -1;

   initial forever begin
      @(posedge ap_clk);
      #2;
      mtick++;
      if (mon_en) begin
         if (stall_dl == mtick) begin chk("stall_release_prod_start", prod_start, 1); stall_dl = -1; end
         if (cons_dl == mtick)  begin chk("cons_launch_after_fill", cons_start, 1); cons_dl = -1; end
         if (done_dl == mtick)  begin chk("done_after_last_cons", ap_done, 1); done_dl = -1; end
         if (prod_start && !pp) begin
            prod_seen++;
            if (exp_prod_q.size() > 0) chk("prod_start_bank", prod_bank, exp_prod_q.pop_front());
         end
         if (cons_start && !cp) begin
            cons_seen++;
            if (exp_cons_q.size() > 0) chk("cons_start_bank", cons_bank, exp_cons_q.pop_front());
         end
         if (ap_done) done_pulses++;
         if (bank_full == 2'b11) saw_full11 = 1'b1;
         if (cons_start && cons_done) begin
            cons_fires++;
            if (bank_full == 2'b11 && !prod_start && prod_seen < cur_nf) stall_dl = mtick + 2;
            if (cons_fires == cur_nf) done_dl = mtick + 2;
         end
         if (prod_start && prod_done && !cons_start && cons_bank == prod_bank) cons_dl = mtick + 2;
      end
      pp = prod_start;
      cp = cons_start;
   end

   typedef struct {
      int   nf;
      int   plat;
      int   clat;
      logic pbank_end;
      logic cbank_end;
      bit   need_full11;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input int idx);
      int waited;
      manual = 1'b0;
      plat = v.plat; clat = v.clat; pcnt = 0; ccnt = 0;
      prod_seen = 0; cons_seen = 0; cons_fires = 0; done_pulses = 0;
      saw_full11 = 1'b0; stall_dl = -1; cons_dl = -1; done_dl = -1;
      cur_nf = v.nf;
      exp_prod_q.delete();
      exp_cons_q.delete();
      for (int i = 0; i < v.nf; i++) begin
         exp_prod_q.push_back(logic'(i % 2));
         exp_cons_q.push_back(logic'(i % 2));
      end
      mon_en = 1'b1;
      ap_start = 1'b1;
      num_frames = 16'(v.nf);
      tick();
      ap_start = 1'b0;
      num_frames = 16'hffff;
      waited = 0;
      while (!ap_done && waited < 3000) begin
         tick();
         waited++;
      end
      chk($sformatf("v%0d_done_seen", idx), ap_done, 1);
      if (v.nf == 0) chk("zero_frames_done_latency", waited, 1);
      chk($sformatf("v%0d_ap_ready", idx), ap_ready, 1);
      chk($sformatf("v%0d_prod_bank_end", idx), prod_bank, v.pbank_end);
      chk($sformatf("v%0d_cons_bank_end", idx), cons_bank, v.cbank_end);
      chk($sformatf("v%0d_bank_full_end", idx), bank_full, 0);
      tick();
      chk($sformatf("v%0d_done_one_cycle", idx), ap_done, 0);
      chk($sformatf("v%0d_idle_after", idx), ap_idle, 1);
      mon_en = 1'b0;
      chk($sformatf("v%0d_prod_starts", idx), prod_seen, v.nf);
      chk($sformatf("v%0d_cons_starts", idx), cons_seen, v.nf);
      chk($sformatf("v%0d_done_pulses", idx), done_pulses, 1);
      if (v.need_full11) chk($sformatf("v%0d_stall_full11", idx), saw_full11, 1);
      manual = 1'b1;
   endtask

   initial begin
      vecs[0] = '{nf: 0, plat: 2, clat: 2,  pbank_end: 1'b0, cbank_end: 1'b0, need_full11: 1'b0};
      vecs[1] = '{nf: 1, plat: 5, clat: 5,  pbank_end: 1'b1, cbank_end: 1'b1, need_full11: 1'b0};
      vecs[2] = '{nf: 4, plat: 3, clat: 20, pbank_end: 1'b0, cbank_end: 1'b0, need_full11: 1'b1};
      vecs[3] = '{nf: 3, plat: 2, clat: 2,  pbank_end: 1'b1, cbank_end: 1'b1, need_full11: 1'b0};
      vecs[4] = '{nf: 5, plat: 4, clat: 2,  pbank_end: 1'b1, cbank_end: 1'b1, need_full11: 1'b0};

      // Reset values, no clock edge needed.
      #1 ap_rst_n = 1'b0;
      ap_start = 1'b1;
      #1;
      chk("rst_prod_start", prod_start, 0);
      chk("rst_cons_start", cons_start, 0);
      chk("rst_ap_done", ap_done, 0);
      chk("rst_ap_ready", ap_ready, 0);
      chk("rst_bank_full", bank_full, 0);
      chk("rst_banks", {prod_bank, cons_bank}, 0);
      chk("rst_idle_with_start", ap_idle, 0);
      ap_start = 1'b0;
      #1 chk("rst_idle_no_start", ap_idle, 1);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Spurious done, simultaneous done and ignored ap_start; stages driven by hand.
      ap_start = 1'b1;
      num_frames = 16'd3;
      tick();
      ap_start = 1'b0;
      chk("hs_no_prod_start_yet", prod_start, 0);
      tick();
      chk("hs_prod_start", prod_start, 1);
      chk("hs_prod_bank0", prod_bank, 0);
      man_cons_done = 1'b1;
      #1;
      chk("spurious_cons_continue", cons_continue, 1);
      chk("spurious_prod_continue_low", prod_continue, 0);
      tick();
      man_cons_done = 1'b0;
      chk("spurious_bank_full", bank_full, 0);
      chk("spurious_cons_bank", cons_bank, 0);
      chk("spurious_cons_start", cons_start, 0);
      man_prod_done = 1'b1;
      #1 chk("prod_continue_echo", prod_continue, 1);
      tick();
      man_prod_done = 1'b0;
      chk("fill0_bank_full", bank_full, 2'b01);
      chk("fill0_prod_bank", prod_bank, 1);
      chk("fill0_prod_start_low", prod_start, 0);
      chk("fill0_cons_start_low", cons_start, 0);
      tick();
      chk("fill0_prod_relaunch", prod_start, 1);
      chk("fill0_cons_launch", cons_start, 1);
      man_prod_done = 1'b1;
      man_cons_done = 1'b1;
      tick();
      man_prod_done = 1'b0;
      man_cons_done = 1'b0;
      chk("simul_bank_full", bank_full, 2'b10);
      chk("simul_banks", {prod_bank, cons_bank}, 2'b01);
      chk("simul_starts_low", {prod_start, cons_start}, 0);
      ap_start = 1'b1;
      num_frames = 16'd0;
      tick();
      ap_start = 1'b0;
      num_frames = 16'd3;
      tick();
      chk("simul_relaunch_starts", {prod_start, cons_start}, 2'b11);
      chk("run_ignores_ap_start", ap_done, 0);
      man_prod_done = 1'b1;
      man_cons_done = 1'b1;
      tick();
      man_prod_done = 1'b0;
      man_cons_done = 1'b0;
      chk("simul2_bank_full", bank_full, 2'b01);
      chk("simul2_banks", {prod_bank, cons_bank}, 2'b10);
      tick();
      tick();
      chk("last_cons_start", cons_start, 1);
      chk("prod_stops_at_frames", prod_start, 0);
      man_cons_done = 1'b1;
      tick();
      man_cons_done = 1'b0;
      chk("last_cons_not_done_yet", ap_done, 0);
      tick();
      chk("hs_ap_done", ap_done, 1);
      chk("hs_end_banks", {prod_bank, cons_bank}, 2'b11);
      chk("hs_end_bank_full", bank_full, 0);
      tick();
      chk("hs_idle", ap_idle, 1);

      // Asynchronous reset in the middle of a run.
      ap_start = 1'b1;
      num_frames = 16'd2;
      tick();
      ap_start = 1'b0;
      tick();
      chk("midrun_prod_start", prod_start, 1);
      #3 ap_rst_n = 1'b0;
      #1;
      chk("midrun_rst_prod_start", prod_start, 0);
      chk("midrun_rst_cons_start", cons_start, 0);
      chk("midrun_rst_done_ready", {ap_done, ap_ready}, 0);
      chk("midrun_rst_bank_full", bank_full, 0);
      chk("midrun_rst_banks", {prod_bank, cons_bank}, 0);
      chk("midrun_rst_idle", ap_idle, 1);
      tick();
      ap_rst_n = 1'b1;
      tick();
      chk("midrun_release_idle", ap_idle, 1);
      chk("midrun_release_prod_start", prod_start, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
